uart_cmd_ctrl: RTL and testbench

- Command controller behind the UART receiver.
- Consumes the received byte stream (valid pulse per byte, no backpressure) and parses fixed 5-byte frames.
- Executes one register write or read on a simple single-cycle register bus.
- Sequences a 2-byte response out through a valid/ready handshake to the UART transmitter.

---
 rtl/uart_cmd_ctrl_if.sv | 27 ++
 rtl/uart_cmd_ctrl.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between the UART command controller, the UART RX/TX and the register bus.
interface uart_cmd_ctrl_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       o_reg_wr;
    logic       o_reg_rd;
    logic [7:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic [7:0] i_reg_rdata;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic       o_busy;
    logic [7:0] o_err_cnt;

    modport master (
        input  i_rx_data, i_rx_valid, i_reg_rdata, i_tx_ready,
        output o_reg_wr, o_reg_rd, o_reg_addr, o_reg_wdata, o_tx_data, o_tx_valid, o_busy,
               o_err_cnt
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_reg_rdata, i_tx_ready,
        input  o_reg_wr, o_reg_rd, o_reg_addr, o_reg_wdata, o_tx_data, o_tx_valid, o_busy,
               o_err_cnt
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses SYNC/CMD/ADDR/DATA/CHK frames, runs one register access and
// returns a 2-byte response. Define UART_CMD_CTRL_TIMEOUT_EN to abort frames stalled mid-way.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [7:0]  ACK_BYTE    = 8'h5A,
    parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
    input logic             clk,
    input logic             rst_n,
    uart_cmd_ctrl_if.master bus
);
    localparam logic [7:0] CMD_WR     = 8'h01;
    localparam logic [7:0] CMD_RD     = 8'h02;
    localparam logic [7:0] ST_BAD_CHK = 8'h01;
    localparam logic [7:0] ST_BAD_CMD = 8'h02;

    typedef enum logic [3:0] {
        StIdle, StCmd, StAddr, StData, StChk, StExec, StCapt, StTx0, StTx1
    } state_e;

    state_e     state;
    logic [7:0] cmd_byte, addr_byte, data_byte, status, payload;
    logic       err_flag;
    logic       reg_wr, reg_rd, tx_valid;
    logic [7:0] reg_addr, reg_wdata, tx_data, err_cnt;

    logic       in_frame, overrun, tx_fire, timeout_hit;
    logic [1:0] err_inc;
    logic [8:0] err_sum;
    logic [7:0] err_next;

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    assign in_frame = state inside {StCmd, StAddr, StData, StChk};
    assign overrun  = bus.i_rx_valid && (state inside {StExec, StCapt, StTx0, StTx1});
    assign tx_fire  = tx_valid && bus.i_tx_ready;

`ifdef UART_CMD_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    assign timeout_hit = in_frame && !bus.i_rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Overrun and a bad-frame capture can land in the same cycle, hence up to +2.
    always_comb begin
        err_inc = 2'd0;
        if (overrun)                     err_inc = err_inc + 2'd1;
        if (state == StCapt && err_flag) err_inc = err_inc + 2'd1;
        if (timeout_hit)                 err_inc = err_inc + 2'd1;
    end

    assign err_sum  = {1'b0, err_cnt} + {7'd0, err_inc};
    assign err_next = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            cmd_byte  <= 8'h00;
            addr_byte <= 8'h00;
            data_byte <= 8'h00;
            status    <= 8'h00;
            payload   <= 8'h00;
            err_flag  <= 1'b0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            err_cnt   <= 8'h00;
        end else begin
            err_cnt <= err_next;
            reg_wr  <= 1'b0;
            reg_rd  <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.i_rx_valid && bus.i_rx_data == SYNC_BYTE) state <= StCmd;
                end
                StCmd: begin
                    if (bus.i_rx_valid) begin
                        cmd_byte <= bus.i_rx_data;
                        state    <= StAddr;
                    end
                end
                StAddr: begin
                    if (bus.i_rx_valid) begin
                        addr_byte <= bus.i_rx_data;
                        state     <= StData;
                    end
                end
                StData: begin
                    if (bus.i_rx_valid) begin
                        data_byte <= bus.i_rx_data;
                        state     <= StChk;
                    end
                end
                StChk: begin
                    if (bus.i_rx_valid) begin
                        if (bus.i_rx_data != (cmd_byte ^ addr_byte ^ data_byte)) begin
                            err_flag <= 1'b1;
                            status   <= ST_BAD_CHK;
                            state    <= StCapt;
                        end else if (cmd_byte != CMD_WR && cmd_byte != CMD_RD) begin
                            err_flag <= 1'b1;
                            status   <= ST_BAD_CMD;
                            state    <= StCapt;
                        end else begin
                            err_flag  <= 1'b0;
                            reg_addr  <= addr_byte;
                            reg_wdata <= data_byte;
                            reg_wr    <= (cmd_byte == CMD_WR);
                            reg_rd    <= (cmd_byte == CMD_RD);
                            state     <= StExec;
                        end
                    end
                end
                StExec: state <= StCapt;
                StCapt: begin
                    if (err_flag)               payload <= status;
                    else if (cmd_byte == CMD_RD) payload <= bus.i_reg_rdata;
                    else                        payload <= data_byte;
                    tx_data  <= err_flag ? NAK_BYTE : ACK_BYTE;
                    tx_valid <= 1'b1;
                    state    <= StTx0;
                end
                StTx0: begin
                    if (tx_fire) begin
                        tx_data <= payload;
                        state   <= StTx1;
                    end
                end
                StTx1: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
`ifdef UART_CMD_CTRL_TIMEOUT_EN
            // Stalled frame: drop it without a response.
            if (in_frame && !bus.i_rx_valid) begin
                if (timeout_hit) begin
                    tmo_cnt <= '0;
                    state   <= StIdle;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
`ifdef UART_CMD_CTRL_TIMEOUT_EN
        if (!rst_n) tmo_cnt <= '0;
`endif
    end

    assign bus.o_reg_wr    = reg_wr;
    assign bus.o_reg_rd    = reg_rd;
    assign bus.o_reg_addr  = reg_addr;
    assign bus.o_reg_wdata = reg_wdata;
    assign bus.o_tx_data   = tx_data;
    assign bus.o_tx_valid  = tx_valid;
    assign bus.o_busy      = (state != StIdle);
    assign bus.o_err_cnt   = err_cnt;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: write/read/error frames, backpressure, overrun,
// saturation, reset mid-response and the stalled-frame behaviour for either macro setting.
module tb_uart_cmd_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(.TIMEOUT_CYC(50)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks    = 0;
    int         errors    = 0;
    int         wr_pulses = 0;
    int         rd_pulses = 0;
    logic [7:0] tx_q[$];

    // Sees the values held during the cycle that the edge closes.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.o_tx_valid && bus.i_tx_ready) tx_q.push_back(bus.o_tx_data);
            if (bus.o_reg_wr) wr_pulses++;
            if (bus.o_reg_rd) rd_pulses++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(k);
    endtask

    task automatic expect_resp(input string tag, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] got0, got1;
        int         guard = 0;
        while (tx_q.size() < 2 && guard < 200) begin
            tick();
            guard++;
        end
        got0 = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
        got1 = (tx_q.size() > 1) ? tx_q[1] : 8'hxx;
        check({tag, "_count"}, tx_q.size(), 2);
        check({tag, "_byte0"}, got0, b0);
        check({tag, "_byte1"}, got1, b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench hung");
    end

    initial begin
        bus.i_rx_data   = 8'h00;
        bus.i_rx_valid  = 1'b0;
        bus.i_reg_rdata = 8'h00;
        bus.i_tx_ready  = 1'b1;
        repeat (3) tick();

        check("rst_tx_valid", bus.o_tx_valid, 0);
        check("rst_tx_data", bus.o_tx_data, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_err_cnt", bus.o_err_cnt, 0);
        check("rst_strobes", {bus.o_reg_wr, bus.o_reg_rd}, 0);
        check("rst_addr", bus.o_reg_addr, 0);
        rst_n = 1'b1;
        tick();

        // Write
        tx_q.delete();
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        check("wr_strobe", {bus.o_reg_wr, bus.o_reg_rd}, 2'b10);
        check("wr_addr", bus.o_reg_addr, 8'h10);
        check("wr_wdata", bus.o_reg_wdata, 8'h3C);
        tick();
        check("wr_pulse_end", bus.o_reg_wr, 0);
        tick();
        check("wr_lat_valid", {bus.o_tx_valid, bus.o_tx_data}, 9'h15A);
        expect_resp("wr", 8'h5A, 8'h3C);
        check("wr_valid_drop", bus.o_tx_valid, 0);
        check("wr_idle", bus.o_busy, 0);
        check("wr_pulses", wr_pulses, 1);
        check("wr_err_cnt", bus.o_err_cnt, 0);

        // Read, with latency from the CHK strobe
        tx_q.delete();
        bus.i_reg_rdata = 8'h77;
        send_frame(8'h02, 8'h20, 8'h00, 8'h22);
        check("rd_strobe", {bus.o_reg_wr, bus.o_reg_rd}, 2'b01);
        check("rd_addr", bus.o_reg_addr, 8'h20);
        tick();
        check("rd_lat_n2", bus.o_tx_valid, 0);
        tick();
        check("rd_lat_n3", bus.o_tx_valid, 1);
        expect_resp("rd", 8'h5A, 8'h77);
        check("rd_pulses", rd_pulses, 1);

        // Bad checksum
        tx_q.delete();
        send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
        expect_resp("badchk", 8'hEE, 8'h01);
        check("badchk_no_wr", wr_pulses, 1);
        check("badchk_err_cnt", bus.o_err_cnt, 1);

        // Junk before SYNC, then bad command
        send_byte(8'h00);
        send_byte(8'hFF);
        check("junk_idle", bus.o_busy, 0);
        check("junk_err_cnt", bus.o_err_cnt, 1);
        tx_q.delete();
        send_frame(8'h07, 8'h00, 8'h00, 8'h07);
        expect_resp("badcmd", 8'hEE, 8'h02);
        check("badcmd_err_cnt", bus.o_err_cnt, 2);
        check("badcmd_no_strobe", wr_pulses + rd_pulses, 2);

        // Backpressure in TX0 with one overrun byte
        tx_q.delete();
        bus.i_tx_ready = 1'b0;
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {bus.o_tx_valid, bus.o_tx_data}, 9'h15A);
            if (i == 4) send_byte(8'h99);
            else tick();
        end
        check("overrun_cnt", bus.o_err_cnt, 3);
        bus.i_tx_ready = 1'b1;
        expect_resp("bp", 8'h5A, 8'h3C);

        // Bad frame plus a byte arriving during capture counts twice
        tx_q.delete();
        send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
        send_byte(8'h55);
        check("double_err_cnt", bus.o_err_cnt, 5);
        expect_resp("double", 8'hEE, 8'h01);

        // Saturation: flood overruns while stalled in TX0
        tx_q.delete();
        bus.i_tx_ready = 1'b0;
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        tick();
        tick();
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b1;
        repeat (300) tick();
        bus.i_rx_valid = 1'b0;
        check("err_sat", bus.o_err_cnt, 255);
        check("sat_tx_hold", bus.o_tx_data, 8'h5A);

        // Reset in the middle of TX1
        bus.i_tx_ready = 1'b1;
        tick();
        bus.i_tx_ready = 1'b0;
        check("tx1_payload", {bus.o_tx_valid, bus.o_tx_data}, 9'h13C);
        rst_n = 1'b0;
        tick();
        check("rst_mid_valid", bus.o_tx_valid, 0);
        check("rst_mid_data", bus.o_tx_data, 0);
        check("rst_mid_err", bus.o_err_cnt, 0);
        check("rst_mid_busy", bus.o_busy, 0);
        check("rst_mid_reg", {bus.o_reg_addr, bus.o_reg_wdata}, 16'h0000);
        rst_n          = 1'b1;
        bus.i_tx_ready = 1'b1;
        tick();

        // Stalled frame
        tx_q.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (60) tick();
`ifdef UART_CMD_CTRL_TIMEOUT_EN
        check("tmo_idle", bus.o_busy, 0);
        check("tmo_err_cnt", bus.o_err_cnt, 1);
        check("tmo_no_tx", tx_q.size(), 0);
        send_frame(8'h01, 8'h33, 8'h44, 8'h76);
        check("tmo_after_addr", bus.o_reg_addr, 8'h33);
        expect_resp("tmo_after", 8'h5A, 8'h44);
        check("tmo_after_err", bus.o_err_cnt, 1);
`else
        check("stall_busy", bus.o_busy, 1);
        check("stall_err_cnt", bus.o_err_cnt, 0);
        check("stall_no_tx", tx_q.size(), 0);
        send_byte(8'h10);
        send_byte(8'h3C);
        send_byte(8'h2D);
        check("stall_wr_addr", bus.o_reg_addr, 8'h10);
        expect_resp("stall_done", 8'h5A, 8'h3C);
        check("stall_err_after", bus.o_err_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
